// File: rtl/i2c_nco_regfile.sv
// I2C slave register file driving NUM_CH NCO channel configs through shadow registers.
// Commit lands one clk after STOP detection; SDA updates ~3 clk after each synchronised SCL edge.
module i2c_nco_regfile #(
  parameter logic [6:0] I2C_ADDR = 7'b1101010,
  parameter int         NUM_CH   = 2,
  parameter int         FREQ_W   = 64,
  parameter int         DUTY_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic [NUM_CH-1:0]        ch_enable,
  output logic [2*NUM_CH-1:0]      ch_wave,
  output logic [FREQ_W*NUM_CH-1:0] ch_freq,
  output logic [DUTY_W*NUM_CH-1:0] ch_duty,
  output logic [NUM_CH-1:0]        cfg_update,
  output logic                     busy
);

  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [8:0] MAP_END  = 9'(NUM_CH * 16);
  localparam logic [7:0] PTR_LAST = 8'(NUM_CH * 16 - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_PTR_ACK  = 4'd4;
  localparam logic [3:0] S_WR       = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD       = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;
  localparam logic [3:0] S_IGNORE   = 4'd9;

  // [0],[1] synchroniser, [2] history; idle-high reset avoids a false START
  logic [2:0] scl_q, sda_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  logic sda_s, scl_rise, scl_fall, start_c, stop_c;
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_c  = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_c   = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

  logic [3:0]        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        sr;
  logic [7:0]        tx;
  logic [7:0]        ptr;
  logic              rw;
  logic              commit_go;

  logic [2:0]        sh_ctrl [NUM_CH];
  logic [FREQ_W-1:0] sh_freq [NUM_CH];
  logic [DUTY_W-1:0] sh_duty [NUM_CH];
  logic [NUM_CH-1:0] sh_dirty;
  logic [2:0]        cm_ctrl [NUM_CH];
  logic [FREQ_W-1:0] cm_freq [NUM_CH];
  logic [DUTY_W-1:0] cm_duty [NUM_CH];

  logic [3:0]        off;
  logic [CH_W-1:0]   ch_sel;
  logic              mapped;
  logic [7:0]        ptr_inc;
  logic              wr_en;

  assign off     = ptr[3:0];
  assign ch_sel  = ptr[4 +: CH_W];
  assign mapped  = {1'b0, ptr} < MAP_END;
  assign ptr_inc = (ptr == PTR_LAST) ? 8'd0 : ptr + 8'd1;
  assign wr_en   = (state == S_WR) && scl_fall && (bit_cnt == 4'd8) && !start_c && !stop_c;

  // Byte lanes are built on 64/16-bit views so bytes above FREQ_W/DUTY_W read 0 and truncate on write
  logic [7:0]  rd_byte;
  logic [63:0] fw;
  logic [15:0] dw;
  logic [6:0]  fsh;
  logic [3:0]  dsh;

  always_comb begin
    rd_byte = 8'd0;
    fw      = 64'd0;
    dw      = 16'd0;
    fsh     = {off - 4'd1, 3'b000};
    dsh     = {off[1], 3'b000};
    if (mapped) begin
      fw = 64'(sh_freq[ch_sel]);
      dw = 16'(sh_duty[ch_sel]);
      if (off == 4'd0)
        rd_byte = {5'd0, sh_ctrl[ch_sel]};
      else if (off <= 4'd8)
        rd_byte = 8'(fw >> fsh);
      else if (off <= 4'd10)
        rd_byte = 8'(dw >> dsh);
      fw = (fw & ~(64'hFF << fsh)) | ({56'd0, sr} << fsh);
      dw = (dw & ~(16'hFF << dsh)) | ({8'd0, sr} << dsh);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      sr        <= 8'd0;
      tx        <= 8'd0;
      ptr       <= 8'd0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      commit_go <= 1'b0;
    end else begin
      commit_go <= 1'b0;
      if (start_c) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_c) begin
        state     <= S_IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        commit_go <= |sh_dirty;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WR: begin
            if (scl_rise) begin
              sr      <= {sr[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (state == S_ADDR) begin
                if (sr[7:1] == I2C_ADDR) begin
                  state  <= S_ADDR_ACK;
                  sda_oe <= 1'b1;
                  rw     <= sr[0];
                end else begin
                  state <= S_IGNORE;
                end
              end else if (state == S_PTR) begin
                ptr    <= sr;
                state  <= S_PTR_ACK;
                sda_oe <= 1'b1;
              end else begin
                ptr    <= ptr_inc;
                state  <= S_WR_ACK;
                sda_oe <= 1'b1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                state  <= S_RD;
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end else begin
                state  <= S_PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              state   <= S_WR;
              bit_cnt <= 4'd0;
              sda_oe  <= 1'b0;
            end
          end
          S_RD: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state  <= S_RD_ACK;
                sda_oe <= 1'b0;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          S_RD_ACK: begin
            // Pointer advances at the ACK sample so the following fall already sees the next byte
            if (scl_rise) begin
              if (!sda_s) ptr <= ptr_inc;
              else        state <= S_IGNORE;
            end else if (scl_fall) begin
              state   <= S_RD;
              bit_cnt <= 4'd0;
              tx      <= rd_byte;
              sda_oe  <= ~rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_dirty   <= '0;
      cfg_update <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sh_ctrl[c] <= '0;
        sh_freq[c] <= '0;
        sh_duty[c] <= '0;
        cm_ctrl[c] <= '0;
        cm_freq[c] <= '0;
        cm_duty[c] <= '0;
      end
    end else begin
      cfg_update <= '0;
      if (commit_go) begin
        sh_dirty <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (sh_dirty[c]) begin
            cm_ctrl[c]    <= sh_ctrl[c];
            cm_freq[c]    <= sh_freq[c];
            cm_duty[c]    <= sh_duty[c];
            cfg_update[c] <= {sh_ctrl[c], sh_freq[c], sh_duty[c]} !=
                             {cm_ctrl[c], cm_freq[c], cm_duty[c]};
          end
        end
      end
      if (wr_en && mapped) begin
        if (off == 4'd0) begin
          sh_ctrl[ch_sel]  <= sr[2:0];
          sh_dirty[ch_sel] <= 1'b1;
        end else if (off <= 4'd8) begin
          sh_freq[ch_sel]  <= FREQ_W'(fw);
          sh_dirty[ch_sel] <= 1'b1;
        end else if (off <= 4'd10) begin
          sh_duty[ch_sel]  <= DUTY_W'(dw);
          sh_dirty[ch_sel] <= 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign ch_enable[c]                    = cm_ctrl[c][0];
    assign ch_wave[2*c +: 2]               = cm_ctrl[c][2:1];
    assign ch_freq[c*FREQ_W +: FREQ_W]     = cm_freq[c];
    assign ch_duty[c*DUTY_W +: DUTY_W]     = cm_duty[c];
  end

endmodule

// File: tb/tb_i2c_nco_regfile.sv
// Directed I2C master with an open-drain bus model and a scoreboard of expected ACKs, read data and outputs.
module tb_i2c_nco_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         scl = 1'b1;
  logic         m_sda = 1'b1;
  logic         sda_bus;
  logic         sda_oe;
  logic [1:0]   ch_enable;
  logic [3:0]   ch_wave;
  logic [127:0] ch_freq;
  logic [23:0]  ch_duty;
  logic [1:0]   cfg_update;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  int           upd_cnt = 0;
  int           oe_cnt = 0;
  logic [1:0]   upd_last = 2'b00;
  int           upd_base;
  int           oe_base;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;
  exp_t exp_q[$];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_nco_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .ch_enable  (ch_enable),
    .ch_wave    (ch_wave),
    .ch_freq    (ch_freq),
    .ch_duty    (ch_duty),
    .cfg_update (cfg_update),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (cfg_update != 2'b00) begin
      upd_cnt  <= upd_cnt + 1;
      upd_last <= cfg_update;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic q();
    repeat (10) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [127:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q();
    scl   = 1'b1; q();
    m_sda = 1'b0; q();
    scl   = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    scl   = 1'b1; q();
    m_sda = 1'b1; q();
    q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; q();
    scl = 1'b1; q();
    b = sda_bus; q();
    scl = 1'b0; q();
  endtask

  task automatic wr(input string tag, input logic [7:0] d, input logic exp_ack);
    logic [7:0] s;
    logic b, a;
    push(tag, {127'd0, exp_ack});
    s = d;
    for (int i = 0; i < 8; i++) begin
      send_bit(s[7]);
      s = {s[6:0], 1'b0};
    end
    get_bit(b);
    a = ~b;
    chk({127'd0, a});
  endtask

  task automatic rd(input string tag, input logic [7:0] exp_d, input logic ack);
    logic [7:0] d;
    logic b;
    push(tag, {120'd0, exp_d});
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    send_bit(~ack);
    chk({120'd0, d});
  endtask

  task automatic chk_upd(input string tag, input int n, input logic [1:0] mask);
    push({tag, "_n"}, 128'(n));
    chk(128'(upd_cnt - upd_base));
    if (n > 0) begin
      push({tag, "_mask"}, {126'd0, mask});
      chk({126'd0, upd_last});
    end
  endtask

  initial begin
    logic [7:0] t1_f [8];
    t1_f = '{8'hE8, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push("rst_ctl", 128'd0);
    chk({118'd0, busy, sda_oe, ch_enable, ch_wave, cfg_update});
    push("rst_freq", 128'd0);
    chk(ch_freq);
    push("rst_duty", 128'd0);
    chk({104'd0, ch_duty});

    // full channel 0 write
    upd_base = upd_cnt;
    i2c_start();
    wr("t1_addr", 8'hD4, 1'b1);
    wr("t1_ptr", 8'h00, 1'b1);
    wr("t1_ctrl", 8'h07, 1'b1);
    for (int i = 0; i < 8; i++) wr("t1_freq_byte", t1_f[i], 1'b1);
    wr("t1_duty0", 8'h00, 1'b1);
    wr("t1_duty1", 8'h08, 1'b1);
    push("t1_busy", 128'd1);
    chk({127'd0, busy});
    i2c_stop();
    push("t1_en", 128'h1);
    chk({126'd0, ch_enable});
    push("t1_wave", 128'h3);
    chk({124'd0, ch_wave});
    push("t1_freq", 128'h3E8);
    chk(ch_freq);
    push("t1_duty", 128'h800);
    chk({104'd0, ch_duty});
    push("t1_busy_end", 128'd0);
    chk({127'd0, busy});
    chk_upd("t1_upd", 1, 2'b01);

    // channel 1 write, repeated START readback, commit only at final STOP
    upd_base = upd_cnt;
    i2c_start();
    wr("t2_addr", 8'hD4, 1'b1);
    wr("t2_ptr", 8'h10, 1'b1);
    wr("t2_ctrl", 8'h03, 1'b1);
    wr("t2_f0", 8'hF4, 1'b1);
    wr("t2_f1", 8'h01, 1'b1);
    i2c_start();
    wr("t2_addr2", 8'hD4, 1'b1);
    wr("t2_ptr2", 8'h10, 1'b1);
    i2c_start();
    wr("t2_addr_rd", 8'hD5, 1'b1);
    rd("t2_rd0", 8'h03, 1'b1);
    rd("t2_rd1", 8'hF4, 1'b1);
    rd("t2_rd2", 8'h01, 1'b0);
    push("t2_hold_freq", 128'h3E8);
    chk(ch_freq);
    push("t2_hold_en", 128'h1);
    chk({126'd0, ch_enable});
    chk_upd("t2_hold_upd", 0, 2'b00);
    i2c_stop();
    push("t2_freq", {64'h1F4, 64'h3E8});
    chk(ch_freq);
    push("t2_en", 128'h3);
    chk({126'd0, ch_enable});
    push("t2_wave", 128'h7);
    chk({124'd0, ch_wave});
    chk_upd("t2_upd", 1, 2'b10);

    // foreign address
    upd_base = upd_cnt;
    oe_base  = oe_cnt;
    i2c_start();
    wr("t3_addr_nack", 8'hAA, 1'b0);
    i2c_stop();
    push("t3_oe", 128'd0);
    chk(128'(oe_cnt - oe_base));
    push("t3_freq", {64'h1F4, 64'h3E8});
    chk(ch_freq);
    chk_upd("t3_upd", 0, 2'b00);

    // reserved byte at 0x1F dropped, pointer wraps to 0x00
    upd_base = upd_cnt;
    i2c_start();
    wr("t4_addr", 8'hD4, 1'b1);
    wr("t4_ptr", 8'h1F, 1'b1);
    wr("t4_rsvd", 8'h5A, 1'b1);
    wr("t4_wrap", 8'h02, 1'b1);
    i2c_stop();
    push("t4_en", 128'h2);
    chk({126'd0, ch_enable});
    push("t4_wave", 128'h5);
    chk({124'd0, ch_wave});
    chk_upd("t4_upd", 1, 2'b01);
    upd_base = upd_cnt;
    i2c_start();
    wr("t4_addr2", 8'hD4, 1'b1);
    wr("t4_ptr2", 8'h1F, 1'b1);
    i2c_start();
    wr("t4_addr_rd", 8'hD5, 1'b1);
    rd("t4_rd_rsvd", 8'h00, 1'b1);
    rd("t4_rd_wrap", 8'h02, 1'b0);
    i2c_stop();
    chk_upd("t4_rd_upd", 0, 2'b00);

    // STOP after 4 bits: partial byte discarded, earlier byte commits
    upd_base = upd_cnt;
    i2c_start();
    wr("t5_addr", 8'hD4, 1'b1);
    wr("t5_ptr", 8'h01, 1'b1);
    wr("t5_f0", 8'h11, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    push("t5_freq", {64'h1F4, 64'h311});
    chk(ch_freq);
    chk_upd("t5_upd", 1, 2'b01);
    i2c_start();
    wr("t5_addr_rd", 8'hD5, 1'b1);
    rd("t5_rd_ptr", 8'h03, 1'b0);
    i2c_stop();

    // asynchronous reset while the slave drives a 0 bit
    i2c_start();
    wr("t6_addr_rd", 8'hD5, 1'b1);
    push("t6_drive", 128'd1);
    chk({127'd0, sda_oe});
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push("t6_async_oe", 128'd0);
    chk({127'd0, sda_oe});
    push("t6_rst_freq", 128'd0);
    chk(ch_freq);
    push("t6_rst_ctl", 128'd0);
    chk({94'd0, busy, ch_enable, ch_wave, cfg_update, ch_duty});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_sda = 1'b0; q();
    scl   = 1'b1; q();
    m_sda = 1'b1; q();
    upd_base = upd_cnt;
    i2c_start();
    wr("t6_addr", 8'hD4, 1'b1);
    wr("t6_ptr", 8'h11, 1'b1);
    wr("t6_f0", 8'h2A, 1'b1);
    i2c_stop();
    push("t6_freq", {64'h2A, 64'h0});
    chk(ch_freq);
    chk_upd("t6_upd", 1, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
